alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Command sequencer for the 16-bit ALU datapath. It accepts one operation per valid/ready handshake, drives the 3-bit function-select code (C1/C2/C3 order) into the 8:1 result mux, and executes the operation:
- ADD/SUB nibble-serially over the 4-bit full-adder slice, one slice per clock, with a registered carry.
- Logic and shift operations in one cycle.

It returns the result with carry and zero flags through a held valid/ready output handshake.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, adder slice width; arithmetic takes WIDTH/SLICE EXEC cycles.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOTA, 110 SHL1, 111 SHR1.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B (ignored for NOTA/SHL1/SHR1).
- sel  out  3  mux select to datapath; sel[0]=C1, sel[1]=C2, sel[2]=C3.
- busy  out  1  high in EXEC or DONE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  result.
- res_carry  out  1  carry flag.
- res_zero  out  1  zero flag.

## Operation
FSM states: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - Latch op, A, B.
  - Set slice counter to 0.
  - Set carry register to 0 (ADD) or 1 (SUB, with B inverted at latch).
  - Go to EXEC.
- EXEC, arithmetic: each cycle adds slice k of A and B' plus the carry register. The result writes bits [k*SLICE +: SLICE], the slice carry-out updates the carry register, and k increments. After the slice with k=WIDTH/SLICE-1, go to DONE.
- EXEC, logic/shift: the full-width result is computed in one cycle, then go to DONE.
- DONE: res_valid=1. res_data and the flags are held stable until res_ready=1, then go to IDLE.
- sel = latched op in EXEC/DONE; 000 in IDLE.
- Flags:
  - ADD: carry = carry-out of bit WIDTH-1.
  - SUB: carry = no-borrow (A>=B unsigned).
  - SHL1: carry = A[WIDTH-1].
  - SHR1: carry = A[0].
  - AND/OR/XOR/NOTA: carry = 0.
  - zero = (res_data==0) for every op.
- Arithmetic is modulo 2^WIDTH. Shifts fill with 0.
- Operand inputs are ignored outside the accepting handshake cycle.

## Timing
- Reset (rst_n low at an edge): state=IDLE and all registers are cleared. res_valid=0, res_data=0, res_carry=0, res_zero=0, sel=000, busy=0. cmd_ready is 0 while rst_n is low and 1 from the first cycle after release.
- Reset mid-EXEC or mid-DONE: the in-flight command is discarded and no result is produced.
- Latency from the accepting edge N:
  - ADD/SUB: res_valid rises after edge N+WIDTH/SLICE (N+4 by default).
  - Logic/shift: res_valid rises after edge N+1.
- res_valid stays high indefinitely while res_ready=0. res_ready asserted while res_valid=0 has no effect.
- cmd_ready is 0 throughout EXEC and DONE, so cmd_valid there is not consumed. After the result handshake there is at least one IDLE cycle before the next command is accepted.
- No combinational path from cmd_valid or res_ready to any output other than through the state register.

## Configuration
- ALU_SEQ_FLAGS_EN:
  - Defined: res_carry and res_zero behave as specified.
  - Undefined: res_carry and res_zero are tied to 0 and the flag logic is not compiled. The carry register still exists for the arithmetic slices.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, release -> all outputs 0 during reset; cmd_ready=1 the next cycle; sel=000.
- ADD carry: A=FFFF, B=0001, op=000 -> res_valid exactly 4 cycles after accept; res_data=0000, carry=1, zero=1; sel=000 during EXEC.
- SUB borrow: A=0003, B=0005, op=001 -> res_data=FFFE, carry=0, zero=0. Also A=1234, B=1234 -> res_data=0000, carry=1, zero=1.
- Logic/shift single-cycle: XOR A=A5A5, B=FFFF -> 5A5A after 1 cycle, sel=100. SHR1 A=8001 -> 4000, carry=1. SHL1 A=8001 -> 0002, carry=1.
- Backpressure: res_ready=0 for 10 cycles after ADD 1234+1111 -> res_valid and res_data=2345 stable throughout; cmd_valid pulses in that window are not accepted.
- Reset mid-operation: rst_n=0 at the second EXEC cycle of ADD -> no res_valid ever for that command; the next command 0001+0001 returns 0002.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer for the 16-bit ALU datapath. ADD/SUB run nibble-serially, logic/shift in one cycle.
// Optional macro ALU_SEQ_FLAGS_EN builds the res_carry/res_zero flag logic; otherwise both are tied to 0.
module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [2:0]       sel,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero
);
    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_SHL1 = 3'b110;
    localparam logic [2:0] OP_SHR1 = 3'b111;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k;
    logic             carry_q;

    logic             is_arith;
    logic             last_slice;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_full;
    logic [WIDTH-1:0] arith_res;
    logic [WIDTH-1:0] logic_res;

    // ADD and SUB share opcode prefix 00; SUB's B is already inverted at latch time.
    assign is_arith   = (op_q[2:1] == 2'b00);
    assign last_slice = (k == KW'(NSL - 1));
    assign a_sl       = a_q[k*SLICE +: SLICE];
    assign b_sl       = b_q[k*SLICE +: SLICE];
    assign slice_full = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

    always_comb begin
        arith_res = res_data;
        arith_res[k*SLICE +: SLICE] = slice_full[SLICE-1:0];
    end

    always_comb begin
        logic_res = '0;
        case (op_q)
            OP_AND:  logic_res = a_q & b_q;
            OP_OR:   logic_res = a_q | b_q;
            OP_XOR:  logic_res = a_q ^ b_q;
            OP_NOTA: logic_res = ~a_q;
            OP_SHL1: logic_res = {a_q[WIDTH-2:0], 1'b0};
            OP_SHR1: logic_res = {1'b0, a_q[WIDTH-1:1]};
            default: logic_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            k         <= '0;
            carry_q   <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        a_q       <= cmd_a;
                        b_q       <= (cmd_op == OP_SUB) ? ~cmd_b : cmd_b;
                        k         <= '0;
                        carry_q   <= (cmd_op == OP_SUB);
                        sel       <= cmd_op;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_arith) begin
                        res_data <= arith_res;
                        carry_q  <= slice_full[SLICE];
                        k        <= k + 1'b1;
                        if (last_slice) begin
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        res_data  <= logic_res;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        sel       <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic logic_carry;

    always_comb begin
        logic_carry = 1'b0;
        if (op_q == OP_SHL1) logic_carry = a_q[WIDTH-1];
        else if (op_q == OP_SHR1) logic_carry = a_q[0];
    end

    // Flags are captured on the same edge that enters DONE, so they stay aligned with res_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
        end else if (state == EXEC) begin
            if (is_arith) begin
                if (last_slice) begin
                    res_carry <= slice_full[SLICE];
                    res_zero  <= (arith_res == '0);
                end
            end else begin
                res_carry <= logic_carry;
                res_zero  <= (logic_res == '0);
            end
        end
    end
`else
    assign res_carry = 1'b0;
    assign res_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed commands, expected results queued at issue and checked by a monitor.
module tb_alu_seq_ctrl;
    localparam int WIDTH = 16;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_SHL1 = 3'b110;
    localparam logic [2:0] OP_SHR1 = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       sel;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Each entry is {carry, zero, data}; lat_q holds the cycle count at which res_valid must first appear.
    logic [WIDTH+1:0] exp_q[$];
    int               lat_q[$];
    logic [WIDTH+1:0] mon_e;
    int               mon_l;
    logic             prev_valid = 1'b0;

    alu_seq_ctrl #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .sel       (sel),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic fl(input logic v);
        return v & FLAGS_ON;
    endfunction

    always @(negedge clk) begin
        if (res_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0h, no result expected", res_data);
            end else begin
                mon_e = exp_q.pop_front();
                mon_l = lat_q.pop_front();
                chk("res_data", 32'(res_data), 32'(mon_e[WIDTH-1:0]));
                chk("res_carry", 32'(res_carry), 32'(mon_e[WIDTH+1]));
                chk("res_zero", 32'(res_zero), 32'(mon_e[WIDTH]));
                chk("latency", cyc, mon_l);
            end
        end
        prev_valid = res_valid;
    end

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit expect_res, input logic [WIDTH-1:0] ed, input logic ec,
                        input logic ez, input int lat);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        if (expect_res) begin
            exp_q.push_back({fl(ec), fl(ez), ed});
            lat_q.push_back(cyc + 1 + lat);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_a     = WIDTH'($urandom);
        cmd_b     = WIDTH'($urandom);
        chk("busy_exec", 32'(busy), 32'd1);
        chk("sel_exec", 32'(sel), 32'(op));
        chk("ready_exec", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 32'(res_valid), 0);
            chk("rst_data", 32'(res_data), 0);
            chk("rst_carry", 32'(res_carry), 0);
            chk("rst_zero", 32'(res_zero), 0);
            chk("rst_sel", 32'(sel), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(cmd_ready), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 1);
        chk("sel_idle", 32'(sel), 0);

        send(OP_ADD,  16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b1, 4); wait_drain();
        send(OP_ADD,  16'h0F0F, 16'h00F1, 1, 16'h1000, 1'b0, 1'b0, 4); wait_drain();
        send(OP_SUB,  16'h0003, 16'h0005, 1, 16'hFFFE, 1'b0, 1'b0, 4); wait_drain();
        send(OP_SUB,  16'h1234, 16'h1234, 1, 16'h0000, 1'b1, 1'b1, 4); wait_drain();
        send(OP_SUB,  16'h0005, 16'h0003, 1, 16'h0002, 1'b1, 1'b0, 4); wait_drain();
        send(OP_XOR,  16'hA5A5, 16'hFFFF, 1, 16'h5A5A, 1'b0, 1'b0, 1); wait_drain();
        send(OP_AND,  16'hF0F0, 16'h3C3C, 1, 16'h3030, 1'b0, 1'b0, 1); wait_drain();
        send(OP_OR,   16'h00F0, 16'h0F00, 1, 16'h0FF0, 1'b0, 1'b0, 1); wait_drain();
        send(OP_NOTA, 16'hFFFF, 16'h1234, 1, 16'h0000, 1'b0, 1'b1, 1); wait_drain();
        send(OP_SHR1, 16'h8001, 16'hFFFF, 1, 16'h4000, 1'b1, 1'b0, 1); wait_drain();
        send(OP_SHL1, 16'h8001, 16'hFFFF, 1, 16'h0002, 1'b1, 1'b0, 1); wait_drain();
        send(OP_SHL1, 16'h4000, 16'h0000, 1, 16'h8000, 1'b0, 1'b0, 1); wait_drain();
        send(OP_SHR1, 16'h0001, 16'h0000, 1, 16'h0000, 1'b1, 1'b1, 1); wait_drain();

        // Backpressure: result must hold and stray commands must be ignored.
        res_ready = 1'b0;
        send(OP_ADD, 16'h1234, 16'h1111, 1, 16'h2345, 1'b0, 1'b0, 4);
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(res_valid), 1);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i % 3 == 0);
            cmd_op    = OP_OR;
            cmd_a     = WIDTH'($urandom);
            cmd_b     = WIDTH'($urandom);
            @(negedge clk);
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_data", 32'(res_data), 32'h2345);
            chk("bp_ready", 32'(cmd_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_released_valid", 32'(res_valid), 0);
        chk("bp_released_busy", 32'(busy), 0);
        repeat (8) @(negedge clk);

        // Reset during the second EXEC cycle discards the command.
        send(OP_ADD, 16'h00FF, 16'h0001, 0, 16'h0000, 1'b0, 1'b0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(res_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_sel", 32'(sel), 0);
        chk("midrst_ready", 32'(cmd_ready), 0);
        chk("midrst_data", 32'(res_data), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_result", 32'(res_valid), 0);
        send(OP_ADD, 16'h0001, 16'h0001, 1, 16'h0002, 1'b0, 1'b0, 4); wait_drain();

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
